// File: rtl/avg_stream_framer.sv
// First-word-fall-through sample FIFO that tags frame boundaries (out_last) on a valid/ready stream.
// Latency 1 cycle from new_dat to out_valid when empty; samples arriving when full with no transfer are dropped and flagged.
module avg_stream_framer #(
    parameter int N     = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     new_dat,
    input  logic [N-1:0]             y,
    input  logic [7:0]               frame_len,
    input  logic                     ovf_clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [N-1:0]             out_data,
    output logic                     out_last,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    beat;
    logic [7:0]    len_q;
    logic [7:0]    len_live;
    logic [7:0]    len_cur;
    logic          full;
    logic          transfer;
    logic          wr_en;
    logic          drop;

    assign full     = (count == CNT_FULL);
    assign transfer = out_valid & out_ready;
    assign wr_en    = new_dat & (~full | transfer);
    assign drop     = new_dat & full & ~transfer;

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

    // A zero frame length is treated as single-beat frames; the live value only
    // governs the first beat of a frame, after that the latched copy is used.
    assign len_live = (frame_len == 8'd0) ? 8'd1 : frame_len;
    assign len_cur  = (beat == 8'd0) ? len_live : len_q;
    assign out_last = out_valid & (beat == len_cur - 8'd1);

    // On a full FIFO with a simultaneous transfer, wr_ptr equals rd_ptr; the
    // head is read combinationally before this edge overwrites the slot.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr] <= y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat     <= 8'd0;
            len_q    <= len_live;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (transfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, transfer})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (transfer) begin
                beat <= out_last ? 8'd0 : beat + 8'd1;
                if (beat == 8'd0) begin
                    len_q <= len_live;
                end
            end

            overflow <= drop | (overflow & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_avg_stream_framer.sv
// Directed-vector bench for avg_stream_framer: reset, framing, overflow, full write+read, backpressure, mid-frame reset.
module tb_avg_stream_framer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_dat;
    logic [15:0] y;
    logic [7:0]  frame_len;
    logic        ovf_clr;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        overflow;
    logic [4:0]  fifo_count;

    int total = 0;
    int fails = 0;

    avg_stream_framer #(.N(16), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_dat    (new_dat),
        .y          (y),
        .frame_len  (frame_len),
        .ovf_clr    (ovf_clr),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] exp16;
        logic [15:0] held;
        logic        hold_chk;
        logic        tr;
        logic        wr;
        int          lasts;
        logic [15:0] q[$];

        rst_n = 1'b0; new_dat = 1'b0; y = '0; frame_len = 8'd1; ovf_clr = 1'b0; out_ready = 1'b0;

        // Reset state, with a new_dat strobe that must be ignored
        new_dat = 1'b1; y = 16'h1234;
        step();
        new_dat = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count", fifo_count, 0);
        rst_n = 1'b1;

        // Single sample, frame_len=1
        out_ready = 1'b1; new_dat = 1'b1; y = 16'hFE00;
        step();
        new_dat = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 16'hFE00);
        check("single_last", out_last, 1);
        check("single_count", fifo_count, 1);
        step();
        check("single_count_after", fifo_count, 0);
        check("single_valid_after", out_valid, 0);

        // Frame tagging: 133 samples, frame_len=4, one per cycle, always ready
        frame_len = 8'd4;
        lasts = 0;
        for (int i = 0; i < 133; i++) begin
            exp16 = 16'(-512 + 4 * i);
            new_dat = 1'b1; y = exp16;
            step();
            check("frame_data", out_data, exp16);
            check("frame_last", out_last, ((i % 4) == 3) ? 1 : 0);
            if (out_last) lasts++;
        end
        new_dat = 1'b0;
        check("frame_final_data", out_data, 16'h0010);
        step();
        check("frame_drained", out_valid, 0);
        check("frame_last_count", lasts, 33);

        // Overflow: 19 writes into a stalled 16-deep FIFO
        do_reset();
        frame_len = 8'd1; out_ready = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            new_dat = 1'b1; y = 16'(i);
            step();
            if (i == 16) check("ovf_not_yet", overflow, 0);
        end
        check("ovf_count", fifo_count, 16);
        check("ovf_flag", overflow, 1);
        // Clear and a new drop on the same edge keeps the flag set
        ovf_clr = 1'b1; y = 16'd99;
        step();
        check("ovf_clr_and_drop", overflow, 1);
        new_dat = 1'b0;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("ovf_read", out_data, i);
            step();
        end
        check("ovf_empty", out_valid, 0);

        // Full FIFO with simultaneous write and transfer
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            new_dat = 1'b1; y = 16'(i);
            step();
        end
        new_dat = 1'b1; y = 16'd100; out_ready = 1'b1;
        step();
        new_dat = 1'b0;
        check("fullrw_count", fifo_count, 16);
        check("fullrw_ovf", overflow, 0);
        for (int i = 2; i <= 16; i++) begin
            check("fullrw_read", out_data, i);
            step();
        end
        check("fullrw_last_val", out_data, 100);
        step();
        check("fullrw_empty", fifo_count, 0);

        // Backpressure: random ready, new_dat every third cycle, against a queue model
        do_reset();
        q = {};
        for (int c = 0; c < 90; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            new_dat   = ((c % 3) == 0);
            y         = 16'($urandom);
            hold_chk  = out_valid & ~out_ready;
            held      = out_data;
            tr = (q.size() != 0) && out_ready;
            wr = new_dat && ((q.size() < 16) || tr);
            step();
            if (tr) void'(q.pop_front());
            if (wr) q.push_back(y);
            if (hold_chk) check("bp_stable", out_data, held);
            check("bp_count", fifo_count, q.size());
            if (q.size() != 0) check("bp_data", out_data, q[0]);
        end
        new_dat = 1'b0;
        check("bp_no_ovf", overflow, 0);

        // Reset mid-frame: two beats of a 4-beat frame, then reset
        do_reset();
        frame_len = 8'd4; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            new_dat = 1'b1; y = 16'(10 + i);
            step();
        end
        new_dat = 1'b0; out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b0; new_dat = 1'b1; y = 16'hBEEF;
        step();
        check("mid_valid", out_valid, 0);
        check("mid_data", out_data, 0);
        check("mid_last", out_last, 0);
        check("mid_count", fifo_count, 0);
        check("mid_ovf", overflow, 0);
        rst_n = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            new_dat = 1'b1; y = 16'(20 + i);
            step();
        end
        new_dat = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mid_post_data", out_data, 20 + i);
            check("mid_post_last", out_last, (i == 3) ? 1 : 0);
            step();
        end
        check("mid_post_empty", out_valid, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/avg_stream_framer.md
AVG_STREAM_FRAMER -- requirements
Module: avg_stream_framer

Interface
REQ-001 The module SHALL have parameter N, default 16, giving the width of each averaged sample in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, giving the number of FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL have port clk  input  1  as its single clock; all logic SHALL be rising-edge triggered.
REQ-004 The module SHALL have port rst_n  input  1  as a synchronous, active-low reset.
REQ-005 The module SHALL have port new_dat  input  1  as the strobe marking a new averaged sample from the upstream growing-sum averager.
REQ-006 The module SHALL have port y  input  N  carrying the signed two's-complement averaged sample, sampled when new_dat=1.
REQ-007 The module SHALL have port frame_len  input  8  giving the number of output beats per frame.
REQ-008 The module SHALL have port ovf_clr  input  1  as a single-cycle clear for the overflow flag.
REQ-009 The module SHALL have port out_ready  input  1  as the downstream ready signal.
REQ-010 The module SHALL have port out_valid  output  1  asserting that out_data holds a valid sample.
REQ-011 The module SHALL have port out_data  output  N  carrying the sample at the FIFO head.
REQ-012 The module SHALL have port out_last  output  1  marking the final beat of a frame.
REQ-013 The module SHALL have port overflow  output  1  as a sticky flag set when a sample is dropped.
REQ-014 The module SHALL have port fifo_count  output  clog2(DEPTH)+1  giving the current FIFO occupancy.

Function
REQ-015 A transfer SHALL occur on any rising edge where out_valid=1 and out_ready=1.
REQ-016 A write SHALL occur on any rising edge where new_dat=1 and either fifo_count<DEPTH or a transfer occurs on the same edge.
REQ-017 The FIFO SHALL be first-word-fall-through: out_valid=(fifo_count!=0), and out_data SHALL equal the oldest stored sample.
REQ-018 A sample written at edge k SHALL appear on out_data with out_valid=1 in the cycle after edge k when the FIFO was empty, giving 1-cycle latency.
REQ-019 Data SHALL pass bit-exact, with no sign extension, truncation or reordering.
REQ-020 The read and write pointers SHALL wrap modulo DEPTH.
REQ-021 fifo_count SHALL increment on a write alone, decrement on a transfer alone, and stay unchanged on a simultaneous write and transfer.
REQ-022 If new_dat=1 while fifo_count=DEPTH and no transfer occurs, the sample SHALL be discarded and overflow SHALL be set to 1 on that edge.
REQ-023 overflow SHALL remain 1 until ovf_clr=1 or rst_n=0.
REQ-024 If ovf_clr=1 and a new drop occur on the same edge, overflow SHALL be 1.
REQ-025 out_valid SHALL NOT be deasserted while out_ready=0, and out_data SHALL hold stable under that condition.
REQ-026 A beat counter SHALL count transfers within the current frame.
REQ-027 frame_len SHALL be latched when the beat counter is 0 and a transfer occurs, or at reset; a value of 0 SHALL be treated as 1.
REQ-028 out_last SHALL be 1 when out_valid=1 and beat counter = latched_len-1.
REQ-029 On a transfer with out_last=1, the beat counter SHALL return to 0; on any other transfer it SHALL increment.
REQ-030 Changes to frame_len in the middle of a frame SHALL take effect only at the next frame start.
REQ-031 Dropped samples SHALL NOT advance the beat counter.

Reset
REQ-032 When rst_n=0 at a rising edge, the FIFO SHALL be flushed (pointers=0, fifo_count=0) and beat counter=0, overflow=0, out_valid=0, out_last=0, out_data=0.
REQ-033 During that reset edge, any new_dat SHALL be ignored.
REQ-034 Reset asserted during a frame or while the FIFO is full SHALL discard all content, with no partial frame resuming.

Verification
REQ-035 Single sample: reset, frame_len=1, out_ready=1, new_dat pulse with y=16'hFE00 -> next cycle out_valid=1, out_data=16'hFE00, out_last=1, fifo_count=1; following cycle fifo_count=0.
REQ-036 Frame tagging: frame_len=4, samples -512,-508,...,+16 (133 samples) with out_ready=1 -> out_last on every 4th beat, final frame partial with no out_last, data order preserved.
REQ-037 Overflow: out_ready=0, DEPTH+3 writes of values 1..19 -> fifo_count=16, overflow=1; then out_ready=1 -> output reads 1..16 and values 17..19 are absent.
REQ-038 Full with simultaneous write and transfer: fill to 16, then new_dat with y=100 and out_ready=1 on the same edge -> fifo_count stays 16, overflow stays 0, 100 is read last.
REQ-039 Backpressure: random out_ready with new_dat every third cycle -> out_data stable while out_valid=1 and out_ready=0, and no loss while fifo_count<16.
REQ-040 Reset mid-frame: frame_len=4, after 2 transfers assert rst_n=0 for 1 cycle -> all outputs 0, and the next frame's out_last occurs on its 4th beat.
